// File: rtl/kch_pkg.sv
// Shared types and helpers for the known-cluster-head table.
//   WORD_WIDTH : default width of ID, hop-count and Q-value fields
//   HOPS_INF   : hop count reported when no CH is known
//   kch_better : strict "A better than B" on (Q, hops) only; index ties are
//                resolved by the caller.
package kch_pkg;

  localparam int unsigned WORD_WIDTH = 16;
  localparam logic [WORD_WIDTH-1:0] HOPS_INF = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    UPDATE,
    SELECT,
    DONE
  } kch_state_e;

  typedef struct packed {
    logic                  valid;
    logic [WORD_WIDTH-1:0] id;
    logic [WORD_WIDTH-1:0] hops;
    logic [WORD_WIDTH-1:0] q;
  } kch_entry_t;

  // Higher Q wins; on equal Q fewer hops wins.
  function automatic logic kch_better(input logic [WORD_WIDTH-1:0] qa,
                                      input logic [WORD_WIDTH-1:0] ha,
                                      input logic [WORD_WIDTH-1:0] qb,
                                      input logic [WORD_WIDTH-1:0] hb);
    return (qa > qb) || ((qa == qb) && (ha < hb));
  endfunction

endpackage

// File: rtl/kch_compare.sv
// Full ordering between two table entries, including the index tie-break.
//   a_q/a_hops/a_idx : entry A
//   b_q/b_hops/b_idx : entry B
//   a_better_c       : 1 when A ranks strictly ahead of B
module kch_compare
  import kch_pkg::*;
#(
  parameter int unsigned IDX_W = 2
) (
  input  logic [WORD_WIDTH-1:0] a_q,
  input  logic [WORD_WIDTH-1:0] a_hops,
  input  logic [IDX_W-1:0]      a_idx,
  input  logic [WORD_WIDTH-1:0] b_q,
  input  logic [WORD_WIDTH-1:0] b_hops,
  input  logic [IDX_W-1:0]      b_idx,
  output logic                  a_better_c
);

  always_comb begin
    a_better_c = kch_better(a_q, a_hops, b_q, b_hops) ||
                 ((a_q == b_q) && (a_hops == b_hops) && (a_idx < b_idx));
  end

endmodule

// File: rtl/kch_table.sv
// Known-cluster-head table: keeps up to DEPTH CH candidates and publishes the best.
//   clk, rst            : clock, synchronous active-high reset
//   en_KCH, fCH_*       : insert/update request, accepted when ready=1
//   HB_reset/HB_CHlimit : heartbeat clear and new occupancy limit
//   ready, upd_done, dropped : handshake and completion pulses
//   ch_valid, ch_count, chosenCH, hopsfromCH, chosenQ : published best CH
module kch_table
  import kch_pkg::*;
#(
  parameter int unsigned  WORD_WIDTH = kch_pkg::WORD_WIDTH,
  parameter int unsigned  DEPTH      = 4,
  localparam int unsigned IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_KCH,
  input  logic                  HB_reset,
  input  logic [WORD_WIDTH-1:0] HB_CHlimit,
  input  logic [WORD_WIDTH-1:0] fCH_ID,
  input  logic [WORD_WIDTH-1:0] fCH_Hops,
  input  logic [WORD_WIDTH-1:0] fCH_QValue,
  output logic                  ready,
  output logic                  upd_done,
  output logic                  dropped,
  output logic                  ch_valid,
  output logic [IDX_W:0]        ch_count,
  output logic [WORD_WIDTH-1:0] chosenCH,
  output logic [WORD_WIDTH-1:0] hopsfromCH,
  output logic [WORD_WIDTH-1:0] chosenQ
);

  kch_state_e            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  kch_entry_t            req_q, req_d;
  kch_entry_t            tbl_q [DEPTH];
  kch_entry_t            tbl_d [DEPTH];
  logic [IDX_W:0]        count_q, count_d, limit_q, limit_d;
  logic                  match_found_q, match_found_d, free_found_q, free_found_d;
  logic                  trk_found_q, trk_found_d, drop_q, drop_d;
  logic [IDX_W-1:0]      match_idx_q, match_idx_d, free_idx_q, free_idx_d;
  logic [IDX_W-1:0]      trk_idx_q, trk_idx_d;
  logic                  ready_q, ready_d, upd_done_q, upd_done_d, dropped_q, dropped_d;
  logic                  ch_valid_q, ch_valid_d;
  logic [IDX_W:0]        ch_count_q, ch_count_d;
  logic [WORD_WIDTH-1:0] chosen_id_q, chosen_id_d, chosen_hops_q, chosen_hops_d;
  logic [WORD_WIDTH-1:0] chosen_qv_q, chosen_qv_d;

  kch_entry_t            cur_c;
  logic [WORD_WIDTH-1:0] cmp_a_q_c, cmp_a_hops_c, cmp_b_q_c, cmp_b_hops_c;
  logic [IDX_W-1:0]      cmp_a_idx_c, cmp_b_idx_c, sel_idx_c;
  logic                  cmp_a_better_c, last_c, sel_found_c;
  logic [IDX_W:0]        hb_limit_c;

  assign last_c     = (idx_q == IDX_W'(DEPTH - 1));
  assign hb_limit_c = (HB_CHlimit > WORD_WIDTH'(DEPTH)) ? (IDX_W+1)'(DEPTH)
                                                        : (IDX_W+1)'(HB_CHlimit);

  // Shared comparator: SCAN asks "is the tracked worst better than the current
  // entry" (current is worse); SELECT asks "is the current entry better than best".
  always_comb begin
    cur_c = tbl_q[idx_q];
    if (state_q == SCAN) begin
      cmp_a_q_c    = tbl_q[trk_idx_q].q;
      cmp_a_hops_c = tbl_q[trk_idx_q].hops;
      cmp_a_idx_c  = trk_idx_q;
      cmp_b_q_c    = cur_c.q;
      cmp_b_hops_c = cur_c.hops;
      cmp_b_idx_c  = idx_q;
    end else begin
      cmp_a_q_c    = cur_c.q;
      cmp_a_hops_c = cur_c.hops;
      cmp_a_idx_c  = idx_q;
      cmp_b_q_c    = tbl_q[trk_idx_q].q;
      cmp_b_hops_c = tbl_q[trk_idx_q].hops;
      cmp_b_idx_c  = trk_idx_q;
    end
  end

  kch_compare #(.IDX_W(IDX_W)) u_cmp (
    .a_q        (cmp_a_q_c),
    .a_hops     (cmp_a_hops_c),
    .a_idx      (cmp_a_idx_c),
    .b_q        (cmp_b_q_c),
    .b_hops     (cmp_b_hops_c),
    .b_idx      (cmp_b_idx_c),
    .a_better_c (cmp_a_better_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    req_d         = req_q;
    tbl_d         = tbl_q;
    count_d       = count_q;
    limit_d       = limit_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    trk_found_d   = trk_found_q;
    trk_idx_d     = trk_idx_q;
    drop_d        = drop_q;
    ready_d       = ready_q;
    upd_done_d    = 1'b0;
    dropped_d     = 1'b0;
    ch_valid_d    = ch_valid_q;
    ch_count_d    = ch_count_q;
    chosen_id_d   = chosen_id_q;
    chosen_hops_d = chosen_hops_q;
    chosen_qv_d   = chosen_qv_q;
    sel_found_c   = trk_found_q;
    sel_idx_c     = trk_idx_q;

    unique case (state_q)
      IDLE: begin
        if (en_KCH) begin
          req_d         = '{valid: 1'b1, id: fCH_ID, hops: fCH_Hops, q: fCH_QValue};
          idx_d         = '0;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
          trk_found_d   = 1'b0;
          ready_d       = 1'b0;
          state_d       = SCAN;
        end
      end
      SCAN: begin
        if (cur_c.valid && (cur_c.id == req_q.id)) begin
          match_found_d = 1'b1;
          match_idx_d   = idx_q;
        end
        if (!cur_c.valid && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        // Tracker holds the worst valid entry during SCAN.
        if (cur_c.valid && (!trk_found_q || cmp_a_better_c)) begin
          trk_found_d = 1'b1;
          trk_idx_d   = idx_q;
        end
        if (last_c) state_d = UPDATE;
        else        idx_d   = idx_q + IDX_W'(1);
      end
      UPDATE: begin
        drop_d = 1'b0;
        if (match_found_q) begin
          tbl_d[match_idx_q].hops = req_q.hops;
          tbl_d[match_idx_q].q    = req_q.q;
        end else if (count_q < limit_q) begin
          tbl_d[free_idx_q] = req_q;
          count_d           = count_q + (IDX_W+1)'(1);
        end else if (trk_found_q && kch_better(req_q.q, req_q.hops,
                                               tbl_q[trk_idx_q].q, tbl_q[trk_idx_q].hops)) begin
          tbl_d[trk_idx_q] = req_q;
        end else begin
          drop_d = 1'b1;
        end
        idx_d       = '0;
        trk_found_d = 1'b0;
        state_d     = SELECT;
      end
      SELECT: begin
        // Tracker holds the best valid entry during SELECT.
        if (cur_c.valid && (!trk_found_q || cmp_a_better_c)) begin
          sel_found_c = 1'b1;
          sel_idx_c   = idx_q;
        end
        trk_found_d = sel_found_c;
        trk_idx_d   = sel_idx_c;
        if (last_c) begin
          state_d    = DONE;
          upd_done_d = 1'b1;
          dropped_d  = drop_q;
          ch_count_d = count_q;
          ch_valid_d = sel_found_c;
          if (sel_found_c) begin
            chosen_id_d   = tbl_q[sel_idx_c].id;
            chosen_hops_d = tbl_q[sel_idx_c].hops;
            chosen_qv_d   = tbl_q[sel_idx_c].q;
          end else begin
            chosen_id_d   = '0;
            chosen_hops_d = WORD_WIDTH'(HOPS_INF);
            chosen_qv_d   = '0;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Heartbeat wipes the table and aborts any request in flight.
    if (HB_reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) tbl_d[i] = '0;
      count_d       = '0;
      limit_d       = hb_limit_c;
      ready_d       = 1'b1;
      upd_done_d    = 1'b0;
      dropped_d     = 1'b0;
      ch_valid_d    = 1'b0;
      ch_count_d    = '0;
      chosen_id_d   = '0;
      chosen_hops_d = WORD_WIDTH'(HOPS_INF);
      chosen_qv_d   = '0;
      state_d       = IDLE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      req_q         <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
      count_q       <= '0;
      limit_q       <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      trk_found_q   <= 1'b0;
      trk_idx_q     <= '0;
      drop_q        <= 1'b0;
      ready_q       <= 1'b1;
      upd_done_q    <= 1'b0;
      dropped_q     <= 1'b0;
      ch_valid_q    <= 1'b0;
      ch_count_q    <= '0;
      chosen_id_q   <= '0;
      chosen_hops_q <= WORD_WIDTH'(HOPS_INF);
      chosen_qv_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      req_q         <= req_d;
      tbl_q         <= tbl_d;
      count_q       <= count_d;
      limit_q       <= limit_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      trk_found_q   <= trk_found_d;
      trk_idx_q     <= trk_idx_d;
      drop_q        <= drop_d;
      ready_q       <= ready_d;
      upd_done_q    <= upd_done_d;
      dropped_q     <= dropped_d;
      ch_valid_q    <= ch_valid_d;
      ch_count_q    <= ch_count_d;
      chosen_id_q   <= chosen_id_d;
      chosen_hops_q <= chosen_hops_d;
      chosen_qv_q   <= chosen_qv_d;
    end
  end

  assign ready      = ready_q;
  assign upd_done   = upd_done_q;
  assign dropped    = dropped_q;
  assign ch_valid   = ch_valid_q;
  assign ch_count   = ch_count_q;
  assign chosenCH   = chosen_id_q;
  assign hopsfromCH = chosen_hops_q;
  assign chosenQ    = chosen_qv_q;

endmodule

// File: tb/tb_kch_table.sv
// Bench for kch_table: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations, then random traffic.
module tb_kch_table;

  localparam int DEPTH = 4;
  localparam int LAT   = 2 * DEPTH + 2;

  logic        clk = 1'b0;
  logic        rst, en_KCH, HB_reset;
  logic [15:0] HB_CHlimit, fCH_ID, fCH_Hops, fCH_QValue;
  logic        ready, upd_done, dropped, ch_valid;
  logic [2:0]  ch_count;
  logic [15:0] chosenCH, hopsfromCH, chosenQ;

  int checks = 0;
  int errors = 0;

  kch_table #(.WORD_WIDTH(16), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .en_KCH     (en_KCH),
    .HB_reset   (HB_reset),
    .HB_CHlimit (HB_CHlimit),
    .fCH_ID     (fCH_ID),
    .fCH_Hops   (fCH_Hops),
    .fCH_QValue (fCH_QValue),
    .ready      (ready),
    .upd_done   (upd_done),
    .dropped    (dropped),
    .ch_valid   (ch_valid),
    .ch_count   (ch_count),
    .chosenCH   (chosenCH),
    .hopsfromCH (hopsfromCH),
    .chosenQ    (chosenQ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    logic [15:0] id;
    logic [15:0] hops;
    logic [15:0] q;
  } ment_t;

  ment_t       mt [DEPTH];
  int          m_count, m_limit, m_cyc;
  bit          m_busy;
  logic [15:0] r_id, r_hops, r_q;
  bit          e_ready, e_done, e_drop, e_valid;
  int          e_count;
  logic [15:0] e_ch, e_hops, e_q;

  // Ranking key: Q first, then hops, then table position.
  function automatic bit m_better(input logic [15:0] qa, input logic [15:0] ha, input int ia,
                                  input logic [15:0] qb, input logic [15:0] hb, input int ib);
    if (qa != qb) return qa > qb;
    if (ha != hb) return ha < hb;
    return ia < ib;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < DEPTH; i++) mt[i].v = 1'b0;
    m_count = 0; m_busy = 1'b0;
    e_ready = 1'b1; e_valid = 1'b0; e_count = 0;
    e_ch = 16'h0; e_hops = 16'hFFFF; e_q = 16'h0;
  endtask

  task automatic m_apply(output bit drp);
    int m = -1; int f = -1; int w = -1;
    drp = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mt[i].v && mt[i].id == r_id) m = i;
      if (!mt[i].v && f < 0) f = i;
    end
    if (m >= 0) begin
      mt[m].hops = r_hops; mt[m].q = r_q;
    end else if (m_count < m_limit) begin
      mt[f].v = 1'b1; mt[f].id = r_id; mt[f].hops = r_hops; mt[f].q = r_q;
      m_count++;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (mt[i].v && (w < 0 || m_better(mt[w].q, mt[w].hops, w, mt[i].q, mt[i].hops, i))) w = i;
      if (w >= 0 && (r_q > mt[w].q || (r_q == mt[w].q && r_hops < mt[w].hops))) begin
        mt[w].id = r_id; mt[w].hops = r_hops; mt[w].q = r_q;
      end else begin
        drp = 1'b1;
      end
    end
  endtask

  task automatic m_select();
    int b = -1;
    for (int i = 0; i < DEPTH; i++)
      if (mt[i].v && (b < 0 || m_better(mt[i].q, mt[i].hops, i, mt[b].q, mt[b].hops, b))) b = i;
    e_count = m_count;
    if (b >= 0) begin
      e_valid = 1'b1; e_ch = mt[b].id; e_hops = mt[b].hops; e_q = mt[b].q;
    end else begin
      e_valid = 1'b0; e_ch = 16'h0; e_hops = 16'hFFFF; e_q = 16'h0;
    end
  endtask

  task automatic m_step();
    bit d;
    e_done = 1'b0; e_drop = 1'b0;
    if (rst) begin
      m_clear(); m_limit = 0;
    end else if (HB_reset) begin
      m_clear();
      m_limit = (int'(HB_CHlimit) > DEPTH) ? DEPTH : int'(HB_CHlimit);
    end else if (!m_busy) begin
      if (en_KCH) begin
        m_busy = 1'b1; m_cyc = 1; e_ready = 1'b0;
        r_id = fCH_ID; r_hops = fCH_Hops; r_q = fCH_QValue;
      end
    end else begin
      m_cyc++;
      if (m_cyc == LAT) begin
        m_apply(d); m_select();
        e_done = 1'b1; e_drop = d;
      end else if (m_cyc == LAT + 1) begin
        m_busy = 1'b0; e_ready = 1'b1;
      end
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(posedge clk);
      m_step();
      #1;
      chk("ready",      32'(ready),      32'(e_ready));
      chk("upd_done",   32'(upd_done),   32'(e_done));
      chk("dropped",    32'(dropped),    32'(e_drop));
      chk("ch_valid",   32'(ch_valid),   32'(e_valid));
      chk("ch_count",   32'(ch_count),   32'(e_count));
      chk("chosenCH",   32'(chosenCH),   32'(e_ch));
      chk("hopsfromCH", 32'(hopsfromCH), 32'(e_hops));
      chk("chosenQ",    32'(chosenQ),    32'(e_q));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 40) begin @(negedge clk); n++; end
  endtask

  task automatic hb(input logic [15:0] lim);
    HB_reset = 1'b1; HB_CHlimit = lim;
    @(negedge clk);
    HB_reset = 1'b0;
  endtask

  // Issues one request and returns in the cycle upd_done is high (or on timeout).
  task automatic do_op(input logic [15:0] id, input logic [15:0] hp, input logic [15:0] q,
                       input bit poke, output int lat, output bit drp);
    lat = 0; drp = 1'b0;
    wait_ready();
    en_KCH = 1'b1; fCH_ID = id; fCH_Hops = hp; fCH_QValue = q;
    @(negedge clk);
    en_KCH = 1'b0;
    fCH_ID = 16'($urandom); fCH_Hops = 16'($urandom); fCH_QValue = 16'($urandom);
    for (int c = 1; c <= 40; c++) begin
      if (poke && c == 3) begin
        en_KCH = 1'b1; fCH_ID = 16'd99; fCH_Hops = 16'd0; fCH_QValue = 16'hFFFF;
      end else begin
        en_KCH = 1'b0;
      end
      if (upd_done) begin lat = c; drp = dropped; break; end
      @(negedge clk);
    end
    en_KCH = 1'b0;
    chk("upd_done_seen", 32'(upd_done), 32'd1);
  endtask

  task automatic do_abort(input logic [15:0] id, input int k, input logic [15:0] lim);
    wait_ready();
    en_KCH = 1'b1; fCH_ID = id; fCH_Hops = 16'd1; fCH_QValue = 16'h2000;
    @(negedge clk);
    en_KCH = 1'b0;
    repeat (k - 1) @(negedge clk);
    hb(lim);
  endtask

  task automatic chk_out(input string tag, input logic [15:0] ch, input logic [15:0] hp,
                         input int cnt, input bit vld);
    chk({tag, "_chosenCH"},   32'(chosenCH),   32'(ch));
    chk({tag, "_hopsfromCH"}, 32'(hopsfromCH), 32'(hp));
    chk({tag, "_ch_count"},   32'(ch_count),   32'(cnt));
    chk({tag, "_ch_valid"},   32'(ch_valid),   32'(vld));
  endtask

  logic [15:0] qtab [4];

  initial begin
    int lat;
    bit drp;
    qtab[0] = 16'h1000; qtab[1] = 16'h2000; qtab[2] = 16'h3000; qtab[3] = 16'h3800;
    rst = 1'b1; en_KCH = 1'b0; HB_reset = 1'b0; HB_CHlimit = 16'd0;
    fCH_ID = 16'd0; fCH_Hops = 16'd0; fCH_QValue = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_upd_done", 32'(upd_done), 32'd0);
    chk("rst_chosenQ", 32'(chosenQ), 32'd0);
    chk_out("rst", 16'd0, 16'hFFFF, 0, 1'b0);
    rst = 1'b0;

    hb(16'd3);
    // Basic insert and latency
    do_op(16'd23, 16'd2, 16'h3000, 1'b0, lat, drp);
    chk("t1_latency", 32'(lat), 32'(LAT));
    chk("t1_dropped", 32'(drp), 32'd0);
    chk("t1_chosenQ", 32'(chosenQ), 32'h3000);
    chk_out("t1", 16'd23, 16'd2, 1, 1'b1);
    do_op(16'd45, 16'd2, 16'h2000, 1'b0, lat, drp);
    chk_out("t2a", 16'd23, 16'd2, 2, 1'b1);
    do_op(16'd45, 16'd3, 16'h3800, 1'b0, lat, drp);
    chk_out("t2b", 16'd45, 16'd3, 2, 1'b1);
    // Fill to limit, drop a weak candidate, evict the worst
    do_op(16'd7, 16'd4, 16'h1000, 1'b0, lat, drp);
    chk_out("t3a", 16'd45, 16'd3, 3, 1'b1);
    do_op(16'd9, 16'd4, 16'h0800, 1'b0, lat, drp);
    chk("t3b_dropped", 32'(drp), 32'd1);
    chk_out("t3b", 16'd45, 16'd3, 3, 1'b1);
    do_op(16'd11, 16'd4, 16'h1800, 1'b0, lat, drp);
    chk("t3c_dropped", 32'(drp), 32'd0);
    chk_out("t3c", 16'd45, 16'd3, 3, 1'b1);
    do_op(16'd7, 16'd4, 16'h0100, 1'b0, lat, drp);
    chk("t3d_id7_gone_drop", 32'(drp), 32'd1);
    // Tie-breaks: fewer hops, then lower index
    do_op(16'd23, 16'd1, 16'h3800, 1'b0, lat, drp);
    chk_out("t4a", 16'd23, 16'd1, 3, 1'b1);
    do_op(16'd45, 16'd1, 16'h3800, 1'b0, lat, drp);
    chk_out("t4b", 16'd23, 16'd1, 3, 1'b1);
    // Heartbeat abort mid-scan
    do_abort(16'd50, 3, 16'd3);
    chk("t5_ready", 32'(ready), 32'd1);
    chk("t5_chosenQ", 32'(chosenQ), 32'd0);
    chk_out("t5", 16'd0, 16'hFFFF, 0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      chk("t5_no_upd_done", 32'(upd_done), 32'd0);
      @(negedge clk);
    end
    // Heartbeat beats a simultaneous request
    HB_reset = 1'b1; HB_CHlimit = 16'd3; en_KCH = 1'b1; fCH_ID = 16'd60;
    @(negedge clk);
    HB_reset = 1'b0; en_KCH = 1'b0;
    chk("t5_hb_priority_ready", 32'(ready), 32'd1);
    // Request while busy is ignored
    do_op(16'd31, 16'd2, 16'h2000, 1'b1, lat, drp);
    chk_out("t5b", 16'd31, 16'd2, 1, 1'b1);
    repeat (2) @(negedge clk);
    chk("t5b_idle_ready", 32'(ready), 32'd1);
    chk("t5b_count", 32'(ch_count), 32'd1);
    // Limit 0 and clamp above DEPTH
    hb(16'd0);
    do_op(16'd70, 16'd1, 16'h3000, 1'b0, lat, drp);
    chk("t6a_dropped", 32'(drp), 32'd1);
    chk_out("t6a", 16'd0, 16'hFFFF, 0, 1'b0);
    hb(16'd9);
    for (int i = 1; i <= 4; i++) do_op(16'(i), 16'd1, 16'(i * 16'h1000), 1'b0, lat, drp);
    chk_out("t6b", 16'd4, 16'd1, 4, 1'b1);
    do_op(16'd5, 16'd1, 16'h0500, 1'b0, lat, drp);
    chk("t6c_dropped", 32'(drp), 32'd1);
    chk_out("t6c", 16'd4, 16'd1, 4, 1'b1);
    do_op(16'd6, 16'd1, 16'h5000, 1'b0, lat, drp);
    chk("t6d_dropped", 32'(drp), 32'd0);
    chk_out("t6d", 16'd6, 16'd1, 4, 1'b1);
    do_op(16'd1, 16'd1, 16'h0100, 1'b0, lat, drp);
    chk("t6e_id1_gone_drop", 32'(drp), 32'd1);

    // Random traffic, checked by the per-cycle model
    for (int it = 0; it < 250; it++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (r == 0) begin
        hb(16'($urandom_range(0, 6)));
      end else if (r == 1) begin
        do_abort(16'($urandom_range(0, 7)), int'($urandom_range(1, LAT)), 16'($urandom_range(0, 6)));
      end else if (r == 2) begin
        wait_ready();
        HB_reset = 1'b1; HB_CHlimit = 16'($urandom_range(0, 6)); en_KCH = 1'b1;
        @(negedge clk);
        HB_reset = 1'b0; en_KCH = 1'b0;
      end else begin
        do_op(16'($urandom_range(0, 7)), 16'($urandom_range(0, 3)),
              qtab[$urandom_range(0, 3)], ($urandom_range(0, 3) == 0), lat, drp);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/kch_table.md
Name: kch_table

Overview:
- Parametrised successor to the single-entry known-cluster-head selector.
- Holds up to DEPTH cluster-head candidates (ID, hop count, Q-value) learned from CH advertisements.
- Bounds occupancy by the heartbeat CH limit, updates duplicate IDs in place and evicts the worst entry when full.
- Continuously publishes the best CH for the node's routing and transmit logic.

Parameters:
- WORD_WIDTH, 16, width of ID, hop and Q-value fields (Q-value unsigned Q2.14; 16'h4000 = 1.0).
- DEPTH, 4, number of table entries (>=2).
- IDX_W, $clog2(DEPTH), entry index width (derived; not overridden).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- en_KCH  in  1  request: insert/update with current fCH_*; accepted only when ready=1.
- HB_reset  in  1  heartbeat: clear table and latch HB_CHlimit.
- HB_CHlimit  in  WORD_WIDTH  max CHs to keep; effective limit = min(HB_CHlimit, DEPTH).
- fCH_ID  in  WORD_WIDTH  advertised CH ID.
- fCH_Hops  in  WORD_WIDTH  hops to that CH.
- fCH_QValue  in  WORD_WIDTH  advertised Q-value.
- ready  out  1  idle, able to accept en_KCH.
- upd_done  out  1  one-cycle pulse when an accepted request completes.
- dropped  out  1  one-cycle pulse coincident with upd_done when the candidate was rejected.
- ch_valid  out  1  table non-empty; chosen outputs meaningful.
- ch_count  out  IDX_W+1  valid entry count.
- chosenCH  out  WORD_WIDTH  best CH ID.
- hopsfromCH  out  WORD_WIDTH  hops of best CH.
- chosenQ  out  WORD_WIDTH  Q-value of best CH.

Behaviour:
- Reset values (rst=1 at a clk edge):
  - all entries invalid; ch_count=0; limit register=0.
  - ready=1; upd_done=0; dropped=0; ch_valid=0.
  - chosenCH=0; hopsfromCH=16'hFFFF (unreachable); chosenQ=0.
  - state IDLE.
- Ordering "A better than B":
  - higher Q wins;
  - on equal Q, fewer hops wins;
  - on equal Q and hops, lower index wins.
  - "Worst" is the exact inverse ordering; on a full tie the higher index is worst.
- FSM IDLE -> SCAN -> UPDATE -> SELECT -> DONE -> IDLE.
  - IDLE: ready=1. On en_KCH=1, latch fCH_* and go to SCAN with index 0. HB_reset has priority over en_KCH in the same cycle.
  - SCAN: one entry per cycle for DEPTH cycles. Records match slot (valid and ID equal), first free slot, and worst valid slot.
  - UPDATE, one cycle, first applicable rule:
    - match: overwrite hops and Q; count unchanged.
    - count < limit: write first free slot; count+1.
    - else if limit > 0 and candidate better than worst: replace worst.
    - else: drop; no table change.
  - SELECT: one entry per cycle for DEPTH cycles; tracks best valid entry.
  - DONE, one cycle:
    - chosenCH/hopsfromCH/chosenQ/ch_valid/ch_count registered on entry.
    - upd_done=1; dropped=1 if the drop rule applied.
    - if count=0, chosen outputs take their reset values.
- Latency: acceptance edge at cycle 0; upd_done high in cycle 2*DEPTH+2 (10 for DEPTH=4). The next request can be accepted in the following cycle.
- ready=0 in all non-IDLE states. en_KCH while busy is ignored; there is no queueing.
- Outputs hold between operations. The latched request is unaffected by fCH_* changes after acceptance.
- HB_reset in any state, next edge:
  - clear all entries and count; latch the effective limit.
  - chosen outputs and ch_valid take reset values; state IDLE.
  - no upd_done or dropped pulse for the aborted request.
- Limit 0: every new ID is dropped.
- HB_CHlimit > DEPTH: clamped to DEPTH.
- rst overrides HB_reset and en_KCH.

Decomposition:
- Package kch_pkg holds:
  - WORD_WIDTH default and HOPS_INF = 16'hFFFF;
  - state enum {IDLE, SCAN, UPDATE, SELECT, DONE};
  - packed struct kch_entry_t {valid, id, hops, q};
  - function kch_better(qa, ha, qb, hb).
- One combinational sub-module, kch_compare, applies the ordering to two entries and is shared by the worst-tracking and best-tracking scans.
- Table storage and FSM stay in kch_table.

Test Plan (DEPTH=4; all cases after rst, then HB_reset with HB_CHlimit=3):
1. Insert ID 23, hops 2, Q 16'h3000 -> upd_done 10 cycles after acceptance; chosenCH=23, hopsfromCH=2, ch_count=1, ch_valid=1, ready low for cycles 1..10.
2. Then insert ID 45, hops 2, Q 16'h2000 -> chosenCH stays 23, ch_count=2. Then update ID 45 with hops 3, Q 16'h3800 -> chosenCH=45, hopsfromCH=3, ch_count=2.
3. Insert ID 7, Q 16'h1000 -> count=3. Then ID 9, Q 16'h0800 -> dropped=1, count=3. Then ID 11, Q 16'h1800 -> ID 7 evicted, count=3, chosenCH=45.
4. Tie: update ID 23 to Q 16'h3800, hops 1 -> chosenCH=23 (fewer hops than ID 45). Same Q and hops -> lower index wins.
5. HB_reset asserted 3 cycles into SCAN -> next cycle ready=1, ch_valid=0, chosenCH=0, hopsfromCH=16'hFFFF, ch_count=0, no upd_done. en_KCH pulsed while busy -> ignored, count unchanged.
6. HB_CHlimit=0 -> insert dropped. HB_CHlimit=9 -> five distinct inserts give count=4 and a fifth-insert eviction/drop per ordering.
